rip_bp_update_scheduler: RTL

- Sits between execute-stage branch resolution and the predictor's single PHT write port (update / update_index / update_weight / actual).
- Buffers resolved-branch updates in a small FIFO while the pipeline is stalled, because the predictor must not see update asserted during a stall.
- Drains the FIFO one update per unstalled cycle.
- After reset and on flush request, sweeps every PHT entry to WEAKLY_UNTAKEN through the same write port, and asserts busy to hold the front end.

---
 rtl/rip_bp_update_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/rip_bp_update_scheduler.sv
// Branch-predictor update scheduler: queues resolved-branch PHT updates across stalls and sweeps the PHT on reset/flush.
// Optional statistics counters are enabled with the BP_STATS_EN macro.
package rip_bp_pkg;
  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'd0,
    WEAKLY_UNTAKEN   = 2'd1,
    WEAKLY_TAKEN     = 2'd2,
    STRONGLY_TAKEN   = 2'd3
  } rip_bpw_t;
endpackage

module rip_bp_update_scheduler
  import rip_bp_pkg::*;
#(
  parameter int INDEX_WIDTH = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush_req,
  input  logic                   resolve_valid,
  input  logic [INDEX_WIDTH-1:0] resolve_index,
  input  rip_bpw_t               resolve_weight,
  input  logic                   resolve_pred,
  input  logic                   resolve_actual,
  output logic                   resolve_ready,
  output logic                   overflow,
  output logic                   busy,
  output logic                   update,
  output logic [INDEX_WIDTH-1:0] update_index,
  output rip_bpw_t               update_weight,
  output logic                   actual,
`ifdef BP_STATS_EN
  output logic [31:0]            stat_updates,
  output logic [31:0]            stat_mispred,
`endif
  output logic                   dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = INDEX_WIDTH + 1;

  typedef enum logic {ST_SWEEP = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    rip_bpw_t               weight;
`ifdef BP_STATS_EN
    logic                   pred;
`endif
    logic                   actual;
  } entry_t;

  // Handshake: an entry is accepted when resolve_valid && resolve_ready in the
  // same cycle; resolve_ready reflects occupancy at the start of the cycle.
  state_t          r_state;
  logic [CW-1:0]   r_sweep_cnt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  entry_t          r_mem [FIFO_DEPTH];
  logic            r_update;
  logic [INDEX_WIDTH-1:0] r_update_index;
  rip_bpw_t        r_update_weight;
  logic            r_actual;
  logic            r_ready;
  logic            r_overflow;
  logic            r_busy;

  state_t          w_state_nxt;
  logic            w_empty;
  logic            w_enq;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic            w_sweep_done;
  entry_t          w_in_e;
  entry_t          w_issue_e;
  logic [PW-1:0]   w_wr_nxt;
  logic [PW-1:0]   w_rd_nxt;
  logic            w_ready_nxt;

  always_comb begin
    w_in_e.index  = resolve_index;
    w_in_e.weight = resolve_weight;
`ifdef BP_STATS_EN
    w_in_e.pred   = resolve_pred;
`endif
    w_in_e.actual = resolve_actual;
  end

`ifndef BP_STATS_EN
  logic w_unused_pred;
  assign w_unused_pred = resolve_pred;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_enq        = resolve_valid && r_ready;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_issue_e    = r_mem[r_rd_ptr[AW-1:0]];
    w_sweep_done = r_sweep_cnt[INDEX_WIDTH];
    case (r_state)
      ST_SWEEP: if (w_sweep_done) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_push = w_enq;
        if (!stall) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            w_issue = 1'b1;
          end else if (w_enq) begin
            // Empty and unstalled: issue straight into the output register.
            w_push    = 1'b0;
            w_issue   = 1'b1;
            w_issue_e = w_in_e;
          end
        end
      end
      default: w_state_nxt = ST_SWEEP;
    endcase
    w_wr_nxt    = r_wr_ptr + PW'(w_push);
    w_rd_nxt    = r_rd_ptr + PW'(w_pop);
    w_ready_nxt = (w_state_nxt == ST_RUN) &&
                  ((w_wr_nxt ^ w_rd_nxt) != {1'b1, {AW{1'b0}}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_SWEEP;
      r_sweep_cnt     <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_update        <= 1'b0;
      r_update_index  <= '0;
      r_update_weight <= STRONGLY_UNTAKEN;
      r_actual        <= 1'b0;
      r_ready         <= 1'b0;
      r_overflow      <= 1'b0;
      r_busy          <= 1'b1;
    end else if (flush_req) begin
      r_state     <= ST_SWEEP;
      r_sweep_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_update    <= 1'b0;
      r_ready     <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_ready    <= w_ready_nxt;
      r_overflow <= resolve_valid && !r_ready;
      case (r_state)
        ST_SWEEP: begin
          if (w_sweep_done) begin
            r_update <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            // Predictor turns STRONGLY_UNTAKEN + taken into WEAKLY_UNTAKEN.
            r_update        <= 1'b1;
            r_update_index  <= r_sweep_cnt[INDEX_WIDTH-1:0];
            r_update_weight <= STRONGLY_UNTAKEN;
            r_actual        <= 1'b1;
            r_sweep_cnt     <= r_sweep_cnt + CW'(1);
            r_busy          <= 1'b1;
          end
        end
        default: begin
          r_update <= w_issue;
          r_busy   <= 1'b0;
          if (w_issue) begin
            r_update_index  <= w_issue_e.index;
            r_update_weight <= w_issue_e.weight;
            r_actual        <= w_issue_e.actual;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_req && w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_in_e;
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_mispred;

  // Counters survive flush_req; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_updates <= '0;
      r_stat_mispred <= '0;
    end else if (!flush_req && (r_state == ST_RUN) && w_issue) begin
      r_stat_updates <= r_stat_updates + 32'd1;
      if (w_issue_e.pred != w_issue_e.actual) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_updates = r_stat_updates;
  assign stat_mispred = r_stat_mispred;
`endif

  assign resolve_ready = r_ready;
  assign overflow      = r_overflow;
  assign busy          = r_busy;
  assign update        = r_update;
  assign update_index  = r_update_index;
  assign update_weight = r_update_weight;
  assign actual        = r_actual;
  assign dbg_state     = r_state;

endmodule
